// File: rtl/framebuffer_port.sv
// Framebuffer read/write port onto a single-port RAM with fixed read latency.
// Reads win arbitration; returned pixels land in a first-word-fall-through buffer.
module framebuffer_port #(
    parameter int unsigned RAM_WIDTH     = 24,
    parameter int unsigned RAM_DEPTH     = 786432,
    parameter int unsigned RAM_ADDR_BITS = 32,
    parameter int unsigned MEM_ADDR_BITS = 20,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [RAM_ADDR_BITS-1:0] framebuffer_addr,
    input  logic                     framebuffer_addr_valid,
    output logic                     framebuffer_addr_rdy,
    output logic [RAM_WIDTH-1:0]     framebuffer_data,
    output logic                     framebuffer_data_valid,
    input  logic                     framebuffer_data_rdy,
    input  logic [RAM_ADDR_BITS-1:0] wr_addr,
    input  logic [RAM_WIDTH-1:0]     wr_data,
    input  logic                     wr_en,
    output logic                     wr_rdy,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [RAM_WIDTH-1:0]     mem_wdata,
    input  logic [RAM_WIDTH-1:0]     mem_rdata
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [RAM_ADDR_BITS-1:0] DEPTH_LIM = RAM_ADDR_BITS'(RAM_DEPTH);
    localparam logic [CNT_W-1:0]         CNT_MAX   = CNT_W'(FIFO_DEPTH);

    logic [CNT_W-1:0]        r_out_cnt;
    logic [CNT_W-1:0]        r_fifo_cnt;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [RAM_WIDTH-1:0]    r_fifo [FIFO_DEPTH];
    logic [READ_LATENCY-1:0] r_tag_v;
    logic [READ_LATENCY-1:0] r_tag_inr;

    logic                    w_addr_rdy;
    logic                    w_rd_acc;
    logic                    w_rd_inr;
    logic                    w_wr_acc;
    logic                    w_wr_inr;
    logic                    w_push;
    logic                    w_pop;
    logic [RAM_WIDTH-1:0]    w_push_data;

    // Outstanding reads are bounded by buffer space, so a returning word always has a slot.
    assign w_addr_rdy = !rst && (r_out_cnt < CNT_MAX);
    assign w_rd_acc   = framebuffer_addr_valid && w_addr_rdy;
    assign w_rd_inr   = framebuffer_addr < DEPTH_LIM;
    assign w_wr_acc   = wr_en && wr_rdy;
    assign w_wr_inr   = wr_addr < DEPTH_LIM;

    assign framebuffer_addr_rdy   = w_addr_rdy;
    assign wr_rdy                 = !rst && !w_rd_acc;
    assign framebuffer_data_valid = (r_fifo_cnt != '0);
    assign framebuffer_data       = r_fifo[r_rd_ptr];

    assign w_push      = r_tag_v[READ_LATENCY-1];
    assign w_push_data = r_tag_inr[READ_LATENCY-1] ? mem_rdata : '0;
    assign w_pop       = framebuffer_data_valid && framebuffer_data_rdy;

    // RAM command mux; out-of-range requests are accepted without touching the RAM.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_rd_acc) begin
            if (w_rd_inr) begin
                mem_en   = 1'b1;
                mem_addr = framebuffer_addr[MEM_ADDR_BITS-1:0];
            end
        end else if (w_wr_acc && w_wr_inr) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr[MEM_ADDR_BITS-1:0];
            mem_wdata = wr_data;
        end
    end

    // Tag pipeline mirrors the RAM latency so each return knows whether it is real data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_v   <= '0;
            r_tag_inr <= '0;
        end else begin
            r_tag_v[0]   <= w_rd_acc;
            r_tag_inr[0] <= w_rd_acc && w_rd_inr;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                r_tag_v[i]   <= r_tag_v[i-1];
                r_tag_inr[i] <= r_tag_inr[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_cnt <= '0;
        end else if (w_rd_acc && !w_pop) begin
            r_out_cnt <= r_out_cnt + CNT_W'(1);
        end else if (!w_rd_acc && w_pop) begin
            r_out_cnt <= r_out_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_fifo[r_wr_ptr] <= w_push_data;
        end
    end

endmodule
